// File: rtl/shift_add_mult_if.sv
// rtl/shift_add_mult_if.sv - operand/product handshake bundle for shift_add_mult
interface shift_add_mult_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] inp1;
    logic [WIDTH-1:0] inp2;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic [WIDTH-1:0] result_hi;
    logic             busy;

    modport master (
        output in_valid, inp1, inp2, out_ready,
        input  in_ready, out_valid, result, result_hi, busy
    );

    modport slave (
        input  in_valid, inp1, inp2, out_ready,
        output in_ready, out_valid, result, result_hi, busy
    );
endinterface

// File: rtl/shift_add_mult.sv
// rtl/shift_add_mult.sv - iterative unsigned shift-and-add multiplier, one multiplier bit per clock
module shift_add_mult #(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH)
) (
    input  logic           clk,
    input  logic           rst,
    shift_add_mult_if.slave bus
);
    localparam int PW = 2 * WIDTH;

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [PW-1:0]    a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [PW-1:0]    acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [PW-1:0]    res_q, res_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            res_q   <= res_d;
        end
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        res_d   = res_q;
        case (state_q)
            S_IDLE: begin
                if (bus.in_valid) begin
                    a_d     = {{WIDTH{1'b0}}, bus.inp1};
                    b_d     = bus.inp2;
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = S_BUSY;
                end
            end
            S_BUSY: begin
                if (b_q[0]) begin
                    acc_d = acc_q + a_q;
                end
                a_d   = a_q << 1;
                b_d   = b_q >> 1;
                cnt_d = cnt_q + CNT_W'(1);
                // Output register only moves on the final iteration, so a partial sum is never visible.
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    res_d   = acc_d;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (bus.out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign bus.in_ready  = (state_q == S_IDLE);
    assign bus.busy      = (state_q == S_BUSY);
    assign bus.out_valid = (state_q == S_DONE);
    assign bus.result    = res_q[WIDTH-1:0];
    assign bus.result_hi = res_q[PW-1:WIDTH];
endmodule

// File: tb/tb_shift_add_mult.sv
// tb/tb_shift_add_mult.sv - self-checking bench for shift_add_mult against an arithmetic product model
module tb_shift_add_mult;
    localparam int W = 32;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    shift_add_mult_if #(.WIDTH(W)) bus ();
    shift_add_mult #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));

    int errors = 0;
    int checks = 0;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] ref_mul(input logic [31:0] x, input logic [31:0] y);
        return 64'(x) * 64'(y);
    endfunction

    task automatic run_txn(input logic [31:0] x, input logic [31:0] y, input int stall,
                           input bit noise, input bit rnd_ready, input string tag);
        logic [63:0] exp;
        int lat;
        exp = ref_mul(x, y);
        @(negedge clk);
        chk({tag, "_in_ready"}, bus.in_ready, 1);
        bus.inp1 = x;
        bus.inp2 = y;
        bus.in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.inp1 = $urandom;
        bus.inp2 = $urandom;
        chk({tag, "_busy"}, bus.busy, 1);
        lat = 0;
        while (!bus.out_valid && lat < 200) begin
            if (noise) begin
                bus.in_valid = 1'($urandom_range(0, 1));
                bus.inp1 = $urandom;
                bus.inp2 = $urandom;
            end
            if (rnd_ready) bus.out_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            lat++;
        end
        bus.in_valid = 1'b0;
        chk({tag, "_latency"}, lat, W);
        chk({tag, "_product"}, {bus.result_hi, bus.result}, exp);
        for (int i = 0; i < stall; i++) begin
            bus.out_ready = 1'b0;
            if (noise) begin
                bus.in_valid = 1'b1;
                bus.inp1 = $urandom;
                bus.inp2 = $urandom;
            end
            @(negedge clk);
            chk({tag, "_stall_valid"}, bus.out_valid, 1);
            chk({tag, "_stall_product"}, {bus.result_hi, bus.result}, exp);
        end
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.out_ready = 1'b0;
        chk({tag, "_post_valid"}, bus.out_valid, 0);
        chk({tag, "_post_in_ready"}, bus.in_ready, 1);
        chk({tag, "_retained"}, {bus.result_hi, bus.result}, exp);
    endtask

    initial begin
        logic [31:0] rx, ry;
        rst = 1'b1;
        bus.in_valid = 1'b0;
        bus.inp1 = '0;
        bus.inp2 = '0;
        bus.out_ready = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_in_ready", bus.in_ready, 1);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_result", {bus.result_hi, bus.result}, 0);
        rst = 1'b0;

        run_txn(32'd3, 32'd5, 0, 1'b0, 1'b0, "basic");
        run_txn(32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 1'b0, 1'b0, "max");
        run_txn(32'h8000_0000, 32'd2, 0, 1'b0, 1'b0, "msb");
        run_txn(32'd0, 32'h1234_5678, 0, 1'b0, 1'b0, "zero_a");
        run_txn(32'h1234_5678, 32'd0, 0, 1'b0, 1'b0, "zero_b");
        run_txn(32'd7, 32'd9, 10, 1'b1, 1'b0, "stall");
        run_txn(32'd11, 32'd13, 0, 1'b0, 1'b0, "after_stall");

        @(negedge clk);
        bus.inp1 = 32'd2;
        bus.inp2 = 32'd5;
        bus.in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (9) @(negedge clk);
        chk("mid_busy", bus.busy, 1);
        #1 rst = 1'b1;
        #1;
        chk("mid_rst_out_valid", bus.out_valid, 0);
        chk("mid_rst_busy", bus.busy, 0);
        chk("mid_rst_in_ready", bus.in_ready, 1);
        chk("mid_rst_result", {bus.result_hi, bus.result}, 0);
        @(negedge clk);
        rst = 1'b0;
        run_txn(32'd4, 32'd4, 0, 1'b0, 1'b0, "post_rst");

        for (int n = 0; n < 1000; n++) begin
            repeat ($urandom_range(0, 2)) @(negedge clk);
            rx = $urandom;
            ry = $urandom;
            run_txn(rx, ry, int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 1'b1, "rand");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
